// File: rtl/fpu_ret_queue_pkg.sv
// fpu_ret_queue_pkg: shared FPU return-path definitions.
//   FLG_*           bit positions of the IEEE flags inside ret[4:0]
//   ret_word_t      field layout of a 14-bit return word {tag, flags}
//   FPCSR_TE_LSB    position of the per-flag trap enables inside fpcsr
//   trap_enables()  extracts the trap-enable field from fpcsr
package fpu_ret_queue_pkg;
  localparam int FLAG_W = 5;
  localparam int TAG_W  = 9;

  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_DZ = 3;
  localparam int FLG_NV = 4;

  localparam int FPCSR_TE_LSB = 7;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [FLAG_W-1:0] flags;
  } ret_word_t;

  function automatic logic [FLAG_W-1:0] trap_enables(input logic [31:0] csr);
    return csr[FPCSR_TE_LSB +: FLAG_W];
  endfunction
endpackage

// File: rtl/fpu_ret_queue_if.sv
// fpu_ret_queue_if: lane returns from the FPU cluster plus the head-of-queue
// valid/ready handshake towards the consumer.
//   master : FPU lanes + consumer side (drives lane words/enables and out_rdy)
//   slave  : the return queue (drives out_ret/out_vld)
interface fpu_ret_queue_if #(
  parameter int RET_W = 14
);
  logic [RET_W-1:0] u1_ret;
  logic [RET_W-1:0] u3_ret;
  logic [RET_W-1:0] u5_ret;
  logic             u1_ret_en;
  logic             u3_ret_en;
  logic             u5_ret_en;
  logic [RET_W-1:0] out_ret;
  logic             out_vld;
  logic             out_rdy;

  modport master (
    output u1_ret, u3_ret, u5_ret, u1_ret_en, u3_ret_en, u5_ret_en, out_rdy,
    input  out_ret, out_vld
  );

  modport slave (
    input  u1_ret, u3_ret, u5_ret, u1_ret_en, u3_ret_en, u5_ret_en, out_rdy,
    output out_ret, out_vld
  );
endinterface

// File: rtl/fpu_ret_compact.sv
// fpu_ret_compact: packs the asserted lanes (order u1, u3, u5) into
// consecutive slots.
//   i_en     {u5_en, u3_en, u1_en}
//   o_off*   slot offset of each lane relative to the write pointer
//   o_n_enq  number of asserted lanes (0..3)
module fpu_ret_compact (
  input  logic [2:0] i_en,
  output logic [1:0] o_off1,
  output logic [1:0] o_off3,
  output logic [1:0] o_off5,
  output logic [1:0] o_n_enq
);
  assign o_off1  = 2'd0;
  assign o_off3  = {1'b0, i_en[0]};
  assign o_off5  = {1'b0, i_en[0]} + {1'b0, i_en[1]};
  assign o_n_enq = o_off5 + {1'b0, i_en[2]};
endmodule

// File: rtl/fpu_ret_queue.sv
// fpu_ret_queue: collects up to three FPU lane returns per cycle into a FIFO,
// presents the head as registered out_ret/out_vld, accumulates sticky IEEE
// flags and flags lost returns.
//   clk, rst      clock; synchronous active-low reset
//   bus (slave)   lane words/enables in, head out_ret/out_vld/out_rdy
//   fpcsr         [11:7] per-flag trap enables
//   flag_clr      clears sticky, ovf and trap (same-cycle new flags win)
//   stall         registered: fewer than 3 free slots next cycle
//   sticky, ovf   accumulated flags, lost-return indicator
//   trap          trap request; built only when FPU_RET_TRAP_EN is defined,
//                 otherwise tied to 0
module fpu_ret_queue
  import fpu_ret_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int RET_W = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  fpu_ret_queue_if.slave       bus,
  input  logic [31:0]          fpcsr,
  input  logic                 flag_clr,
  output logic                 stall,
  output logic [FLAG_W-1:0]    sticky,
  output logic                 ovf,
  output logic                 trap
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RET_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_out_vld;
  logic [RET_W-1:0]  r_out_ret;
  logic              r_stall;
  logic [FLAG_W-1:0] r_sticky;
  logic              r_ovf;

  logic [2:0]        w_en;
  logic [1:0]        w_off [3];
  logic [1:0]        w_n_enq;
  logic [RET_W-1:0]  w_data [3];
  logic              w_deq;
  logic [CNT_W-1:0]  w_free, w_n_acc, w_count_nxt;
  logic [2:0]        w_acc;
  logic [PTR_W-1:0]  w_slot [3];
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [RET_W-1:0]  w_head;
  logic [FLAG_W-1:0] w_flags_in;
  logic              w_drop;
  logic              w_unused_fpcsr;

  assign w_en      = {bus.u5_ret_en, bus.u3_ret_en, bus.u1_ret_en};
  assign w_data[0] = bus.u1_ret;
  assign w_data[1] = bus.u3_ret;
  assign w_data[2] = bus.u5_ret;

  fpu_ret_compact u_compact (
    .i_en    (w_en),
    .o_off1  (w_off[0]),
    .o_off3  (w_off[1]),
    .o_off5  (w_off[2]),
    .o_n_enq (w_n_enq)
  );

  // The slot being dequeued this cycle is reusable by this cycle's lanes.
  assign w_deq        = r_out_vld & bus.out_rdy;
  assign w_free       = CNT_W'(DEPTH) - r_count + CNT_W'(w_deq);
  assign w_n_acc      = (CNT_W'(w_n_enq) <= w_free) ? CNT_W'(w_n_enq) : w_free;
  assign w_drop       = (w_n_acc != CNT_W'(w_n_enq));
  assign w_count_nxt  = r_count + w_n_acc - CNT_W'(w_deq);
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_deq);

  // Lanes whose offset falls past the free space are the later ones in
  // u1,u3,u5 order, so u5 is dropped first.
  always_comb begin
    w_flags_in = '0;
    for (int k = 0; k < 3; k++) begin
      w_acc[k]  = w_en[k] && (CNT_W'(w_off[k]) < w_n_acc);
      w_slot[k] = r_wr_ptr + PTR_W'(w_off[k]);
      if (w_en[k]) w_flags_in = w_flags_in | w_data[k][FLAG_W-1:0];
    end
  end

  // Next head: a lane written this cycle may land in the head slot when the
  // queue drains to it, so forward it instead of the stale array word.
  always_comb begin
    w_head = r_mem[w_rd_ptr_nxt];
    for (int k = 0; k < 3; k++)
      if (w_acc[k] && (w_slot[k] == w_rd_ptr_nxt)) w_head = w_data[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++)
        if (w_acc[k]) r_mem[w_slot[k]] <= w_data[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out_vld <= 1'b0;
      r_out_ret <= '0;
      r_stall   <= 1'b0;
      r_sticky  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_wr_ptr  <= r_wr_ptr + PTR_W'(w_n_acc);
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_out_vld <= (w_count_nxt != '0);
      if (w_count_nxt != '0) r_out_ret <= w_head;
      r_stall   <= (CNT_W'(DEPTH) - w_count_nxt) < CNT_W'(3);
      r_sticky  <= (flag_clr ? '0 : r_sticky) | w_flags_in;
      r_ovf     <= (r_ovf & ~flag_clr) | w_drop;
    end
  end

`ifdef FPU_RET_TRAP_EN
  logic r_trap;
  logic w_trap_hit;

  always_comb begin
    w_trap_hit = 1'b0;
    for (int k = 0; k < 3; k++)
      if (w_acc[k] && ((w_data[k][FLAG_W-1:0] & trap_enables(fpcsr)) != '0))
        w_trap_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_trap <= 1'b0;
    else      r_trap <= (r_trap & ~flag_clr) | w_trap_hit;
  end

  assign trap = r_trap;
`else
  assign trap = 1'b0;
`endif

  assign w_unused_fpcsr = ^fpcsr;

  assign bus.out_ret = r_out_ret;
  assign bus.out_vld = r_out_vld;
  assign stall       = r_stall;
  assign sticky      = r_sticky;
  assign ovf         = r_ovf;
endmodule
